// File: rtl/jtopl_host_pkg.sv
// jtopl_host_pkg: shared types and constants for the jtopl bus initiator.
package jtopl_host_pkg;

    localparam int CW = 8;

    localparam logic [7:0] IRQ_REG = 8'h04;
    localparam logic [7:0] IRQ_VAL = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        AWR,
        AWAIT,
        DWR,
        DWAIT,
        SRD
    } state_t;

endpackage

// File: rtl/jtopl_host_strobe.sv
// jtopl_host_strobe: shared phase counter plus registered chip-bus strobe/address/data drivers.
// A load sets the phase length and strobe levels; expire_o marks the last cen tick of a phase.
module jtopl_host_strobe
    import jtopl_host_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen_i,
    input  logic          ld_i,
    input  logic [CW-1:0] len_i,
    input  logic          wr_i,
    input  logic          rd_i,
    input  logic          bus_i,
    input  logic          addr_i,
    input  logic [7:0]    din_i,
    output logic          expire_o,
    output logic          opl_addr_o,
    output logic [7:0]    opl_din_o,
    output logic          opl_cs_n_o,
    output logic          opl_wr_n_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          cs_n_q, cs_n_d;
    logic          wr_n_q, wr_n_d;
    logic          addr_q, addr_d;
    logic [7:0]    din_q, din_d;

    assign expire_o = cen_i && cnt_q == CW'(1);

    // Address/data only change on an explicit bus load, so they hold while strobes are high.
    always_comb begin
        cnt_d  = ld_i ? len_i : (cen_i && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        cs_n_d = ld_i ? !(wr_i || rd_i) : cs_n_q;
        wr_n_d = ld_i ? !wr_i : wr_n_q;
        addr_d = bus_i ? addr_i : addr_q;
        din_d  = bus_i ? din_i : din_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            cs_n_q <= 1'b1;
            wr_n_q <= 1'b1;
            addr_q <= 1'b0;
            din_q  <= 8'h00;
        end else begin
            cnt_q  <= cnt_d;
            cs_n_q <= cs_n_d;
            wr_n_q <= wr_n_d;
            addr_q <= addr_d;
            din_q  <= din_d;
        end
    end

    assign opl_addr_o = addr_q;
    assign opl_din_o  = din_q;
    assign opl_cs_n_o = cs_n_q;
    assign opl_wr_n_o = wr_n_q;

endmodule

// File: rtl/jtopl_host.sv
// jtopl_host: request-driven bus initiator for the jtopl register interface (writes and status reads).
// Define JTOPL_HOST_IRQACK_EN to add an automatic IRQ-flag reset write and the irq_ack_o pulse.
module jtopl_host
    import jtopl_host_pkg::*;
#(
    parameter int PULSE     = 2,
    parameter int ADDR_WAIT = 12,
    parameter int DATA_WAIT = 84
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [7:0] req_reg_i,
    input  logic [7:0] req_val_i,
    input  logic       stat_req_i,
    output logic       stat_valid_o,
    output logic [7:0] stat_data_o,
    output logic       busy_o,
    output logic [7:0] opl_din_o,
    output logic       opl_addr_o,
    output logic       opl_cs_n_o,
    output logic       opl_wr_n_o,
    input  logic [7:0] opl_dout_i,
    input  logic       opl_irq_n_i
`ifdef JTOPL_HOST_IRQACK_EN
   ,output logic       irq_ack_o
`endif
);

    state_t        state_q, state_d;
    logic [7:0]    val_q, val_d;
    logic [7:0]    stat_data_q, stat_data_d;
    logic          ready_q, ready_d;
    logic          stat_valid_q, stat_valid_d;
    logic          ld, wr_s, rd_s, bus, addr_l, expire;
    logic          take_ack, ack_go, ack_pend_d;
    logic [CW-1:0] len;
    logic [7:0]    din_l;

    always_comb begin
        state_d      = state_q;
        val_d        = val_q;
        stat_data_d  = stat_data_q;
        stat_valid_d = 1'b0;
        ld           = 1'b0;
        len          = '0;
        wr_s         = 1'b0;
        rd_s         = 1'b0;
        bus          = 1'b0;
        addr_l       = 1'b0;
        din_l        = opl_din_o;
        take_ack     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ack_go) begin
                    state_d  = AWR;
                    take_ack = 1'b1;
                    val_d    = IRQ_VAL;
                    ld       = 1'b1;
                    len      = CW'(PULSE);
                    wr_s     = 1'b1;
                    bus      = 1'b1;
                    din_l    = IRQ_REG;
                end else if (stat_req_i) begin
                    state_d = SRD;
                    ld      = 1'b1;
                    rd_s    = 1'b1;
                    bus     = 1'b1;
                end else if (req_valid_i && ready_q) begin
                    state_d = AWR;
                    val_d   = req_val_i;
                    ld      = 1'b1;
                    len     = CW'(PULSE);
                    wr_s    = 1'b1;
                    bus     = 1'b1;
                    din_l   = req_reg_i;
                end
            end
            AWR: begin
                if (expire) begin
                    state_d = AWAIT;
                    ld      = 1'b1;
                    len     = CW'(ADDR_WAIT);
                end
            end
            AWAIT: begin
                if (expire) begin
                    state_d = DWR;
                    ld      = 1'b1;
                    len     = CW'(PULSE);
                    wr_s    = 1'b1;
                    bus     = 1'b1;
                    addr_l  = 1'b1;
                    din_l   = val_q;
                end
            end
            DWR: begin
                if (expire) begin
                    state_d = DWAIT;
                    ld      = 1'b1;
                    len     = CW'(DATA_WAIT);
                end
            end
            DWAIT: state_d = expire ? IDLE : DWAIT;
            SRD: begin
                state_d      = IDLE;
                ld           = 1'b1;
                stat_valid_d = 1'b1;
                stat_data_d  = opl_dout_i;
            end
            default: state_d = IDLE;
        endcase
        // Ready only after a full idle cycle, so the cycle that re-enters IDLE never accepts.
        ready_d = state_q == IDLE && state_d == IDLE && !ack_pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            val_q        <= 8'h00;
            ready_q      <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_data_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            val_q        <= val_d;
            ready_q      <= ready_d;
            stat_valid_q <= stat_valid_d;
            stat_data_q  <= stat_data_d;
        end
    end

    jtopl_host_strobe u_strobe (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen_i      (cen_i),
        .ld_i       (ld),
        .len_i      (len),
        .wr_i       (wr_s),
        .rd_i       (rd_s),
        .bus_i      (bus),
        .addr_i     (addr_l),
        .din_i      (din_l),
        .expire_o   (expire),
        .opl_addr_o (opl_addr_o),
        .opl_din_o  (opl_din_o),
        .opl_cs_n_o (opl_cs_n_o),
        .opl_wr_n_o (opl_wr_n_o)
    );

`ifdef JTOPL_HOST_IRQACK_EN
    logic irq_q, ack_pend_q, ack_run_q, ack_run_d, irq_ack_q, irq_ack_d;

    assign ack_go     = ack_pend_q;
    assign ack_pend_d = (ack_pend_q && !take_ack) || (irq_q && !opl_irq_n_i);
    assign ack_run_d  = take_ack ? 1'b1 : state_q == IDLE ? 1'b0 : ack_run_q;
    assign irq_ack_d  = ack_run_q && state_q == DWAIT && state_d == IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q      <= 1'b1;
            ack_pend_q <= 1'b0;
            ack_run_q  <= 1'b0;
            irq_ack_q  <= 1'b0;
        end else begin
            irq_q      <= opl_irq_n_i;
            ack_pend_q <= ack_pend_d;
            ack_run_q  <= ack_run_d;
            irq_ack_q  <= irq_ack_d;
        end
    end

    assign irq_ack_o = irq_ack_q;
`else
    logic unused_irq;

    assign ack_go     = 1'b0;
    assign ack_pend_d = 1'b0;
    assign unused_irq = opl_irq_n_i ^ take_ack;
`endif

    assign req_ready_o  = ready_q;
    assign stat_valid_o = stat_valid_q;
    assign stat_data_o  = stat_data_q;
    assign busy_o       = state_q != IDLE;

endmodule

// File: tb/tb_jtopl_host.sv
// tb_jtopl_host: scoreboard bench for jtopl_host; a bus monitor checks every write strobe against expectations.
module tb_jtopl_host;

    localparam int P  = 2;
    localparam int AW = 12;
    localparam int DW = 84;
    localparam int WR_CYC = 2 * P + AW + DW;

    typedef struct {
        logic       addr;
        logic [7:0] din;
        int         len;
        int         gap;
    } strb_t;

    logic       clk = 1'b0, rst_n = 1'b0, cen = 1'b1;
    logic       req_valid = 1'b0, stat_req = 1'b0, opl_irq_n = 1'b1;
    logic [7:0] req_reg = 8'h00, req_val = 8'h00, opl_dout = 8'h00;
    logic       req_ready, stat_valid, busy, opl_addr, opl_cs_n, opl_wr_n;
    logic [7:0] stat_data, opl_din;

    int checks = 0, errors = 0;
    int cyc = 0, cen_div = 1, cen_ph = 0;
    int lo_n = 0, hi_n = 0, s_gap = 0, n_strobes = 0, n_ack = 0;
    logic       s_addr;
    logic [7:0] s_din, chip_idx, sd;
    strb_t      e_m;
    strb_t      exp_q[$];
    logic [7:0] stat_q[$];
    logic [7:0] chip_regs [0:255];

    jtopl_host dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cen_i        (cen),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_reg_i    (req_reg),
        .req_val_i    (req_val),
        .stat_req_i   (stat_req),
        .stat_valid_o (stat_valid),
        .stat_data_o  (stat_data),
        .busy_o       (busy),
        .opl_din_o    (opl_din),
        .opl_addr_o   (opl_addr),
        .opl_cs_n_o   (opl_cs_n),
        .opl_wr_n_o   (opl_wr_n),
        .opl_dout_i   (opl_dout),
        .opl_irq_n_i  (opl_irq_n)
`ifdef JTOPL_HOST_IRQACK_EN
       ,.irq_ack_o    (irq_ack)
`endif
    );

`ifdef JTOPL_HOST_IRQACK_EN
    logic irq_ack;
    always @(negedge clk) if (irq_ack) n_ack++;
`endif

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // cen pattern: high one clk in every cen_div, updated just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        cen_ph = (cen_ph + 1) % cen_div;
        cen = (cen_ph == 0);
    end

    // Chip-side monitor: measures each write strobe and pops the matching expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            lo_n = 0;
            hi_n = 0;
        end else if (!opl_cs_n && !opl_wr_n) begin
            if (lo_n == 0) begin
                s_addr = opl_addr;
                s_din  = opl_din;
                s_gap  = hi_n;
            end else if (opl_addr !== s_addr || opl_din !== s_din) begin
                errors++;
                $display("FAIL strobe_stable: addr/din moved to %b/%h during strobe, required %b/%h", opl_addr, opl_din, s_addr, s_din);
            end
            lo_n++;
        end else if (lo_n != 0) begin
            n_strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: addr=%b din=%h len=%0d, required no strobe", s_addr, s_din, lo_n);
            end else begin
                e_m = exp_q.pop_front();
                if (s_addr !== e_m.addr || s_din !== e_m.din || lo_n != e_m.len || (e_m.gap >= 0 && s_gap != e_m.gap)) begin
                    errors++;
                    $display("FAIL strobe: got addr=%b din=%h len=%0d gap=%0d, required addr=%b din=%h len=%0d gap=%0d",
                             s_addr, s_din, lo_n, s_gap, e_m.addr, e_m.din, e_m.len, e_m.gap);
                end
            end
            if (s_addr) chip_regs[chip_idx] = s_din;
            else chip_idx = s_din;
            lo_n = 0;
            hi_n = 1;
        end else if (hi_n != 0) begin
            hi_n++;
        end
        if (rst_n && stat_valid) begin
            checks++;
            if (stat_q.size() == 0) begin
                errors++;
                $display("FAIL stat_unexpected: stat_valid with data %h, required no pulse", stat_data);
            end else begin
                sd = stat_q.pop_front();
                if (stat_data !== sd) begin
                    errors++;
                    $display("FAIL stat_data: got %h, required %h", stat_data, sd);
                end
            end
        end
    end

    task automatic wait_ready(input string what);
        int n = 0;
        while (req_ready !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) begin
            checks++;
            errors++;
            $display("FAIL %s: req_ready stuck at %b after %0d cycles, required 1", what, req_ready, n);
        end
    endtask

    task automatic send_write(input logic [7:0] r, input logic [7:0] v, input bit align, output int acc);
        int n = 0;
        @(negedge clk);
        while (!(req_ready === 1'b1 && (cen || !align)) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) begin
            checks++;
            errors++;
            $display("FAIL send_wait: req_ready=%b cen=%b never both ready, required ready", req_ready, cen);
        end
        exp_q.push_back('{1'b0, r, P * cen_div, -1});
        exp_q.push_back('{1'b1, v, P * cen_div, AW * cen_div});
        req_valid = 1'b1;
        req_reg   = r;
        req_val   = v;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        acc = cyc;
        checks++;
        if ({busy, req_ready, opl_cs_n, opl_wr_n} !== 4'b1000) begin
            errors++;
            $display("FAIL accept: busy/ready/cs_n/wr_n=%b%b%b%b, required 1000", busy, req_ready, opl_cs_n, opl_wr_n);
        end
    endtask

    task automatic check_lat(input string what, input int acc, input int want);
        checks++;
        if (cyc - acc != want) begin
            errors++;
            $display("FAIL %s: ready after %0d clk, required %0d", what, cyc - acc, want);
        end
    endtask

    task automatic check_reg(input logic [7:0] r, input logic [7:0] v);
        checks++;
        if (chip_regs[r] !== v) begin
            errors++;
            $display("FAIL chip_reg_%h: got %h, required %h", r, chip_regs[r], v);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({opl_cs_n, opl_wr_n, opl_addr, opl_din, req_ready, busy, stat_valid, stat_data} !== {3'b110, 8'h00, 3'b000, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: cs_n=%b wr_n=%b addr=%b din=%h ready=%b busy=%b sv=%b sd=%h, required 1 1 0 00 0 0 0 00",
                     opl_cs_n, opl_wr_n, opl_addr, opl_din, req_ready, busy, stat_valid, stat_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b one clk after release, required 1", req_ready);
        end
    endtask

    task automatic test_single_write;
        int acc;
        chip_regs[8'h20] = 8'h00;
        send_write(8'h20, 8'h01, 1'b0, acc);
        wait_ready("single_ready");
        check_lat("single_latency", acc, 1 + WR_CYC);
        check_reg(8'h20, 8'h01);
    endtask

    task automatic test_status;
        opl_dout = 8'hE6;
        @(negedge clk);
        wait_ready("stat_idle");
        stat_q.push_back(8'hE6);
        stat_req = 1'b1;
        @(negedge clk);
        stat_req = 1'b0;
        checks++;
        if ({busy, opl_cs_n, opl_wr_n, opl_addr, stat_valid} !== 5'b10100) begin
            errors++;
            $display("FAIL stat_strobe: busy/cs_n/wr_n/addr/sv=%b%b%b%b%b, required 10100", busy, opl_cs_n, opl_wr_n, opl_addr, stat_valid);
        end
        @(negedge clk);
        opl_dout = 8'h00;
        checks++;
        if (stat_valid !== 1'b1 || stat_data !== 8'hE6 || opl_cs_n !== 1'b1) begin
            errors++;
            $display("FAIL stat_pulse: sv=%b data=%h cs_n=%b, required 1 e6 1", stat_valid, stat_data, opl_cs_n);
        end
        @(negedge clk);
        checks++;
        if (stat_valid !== 1'b0 || stat_data !== 8'hE6) begin
            errors++;
            $display("FAIL stat_hold: sv=%b data=%h, required 0 e6", stat_valid, stat_data);
        end
    endtask

    task automatic test_stat_vs_write;
        int acc;
        opl_dout = 8'h5A;
        @(negedge clk);
        wait_ready("svw_idle");
        stat_q.push_back(8'h5A);
        exp_q.push_back('{1'b0, 8'h40, P, -1});
        exp_q.push_back('{1'b1, 8'h3F, P, AW});
        stat_req  = 1'b1;
        req_valid = 1'b1;
        req_reg   = 8'h40;
        req_val   = 8'h3F;
        @(negedge clk);
        stat_req = 1'b0;
        checks++;
        if ({busy, opl_cs_n, opl_wr_n} !== 3'b101) begin
            errors++;
            $display("FAIL svw_read_first: busy/cs_n/wr_n=%b%b%b, required 101", busy, opl_cs_n, opl_wr_n);
        end
        @(negedge clk);
        checks++;
        if (stat_valid !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL svw_pulse: sv=%b ready=%b, required 1 0", stat_valid, req_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL svw_ready: ready=%b busy=%b, required 1 0", req_ready, busy);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        acc = cyc;
        checks++;
        if ({busy, opl_cs_n, opl_wr_n, opl_addr, opl_din} !== {4'b1000, 8'h40}) begin
            errors++;
            $display("FAIL svw_accept: busy=%b cs_n=%b wr_n=%b addr=%b din=%h, required 1 0 0 0 40", busy, opl_cs_n, opl_wr_n, opl_addr, opl_din);
        end
        wait_ready("svw_done");
        check_lat("svw_latency", acc, 1 + WR_CYC);
    endtask

    task automatic test_back_to_back;
        int acc;
        @(negedge clk);
        wait_ready("b2b_idle");
        exp_q.push_back('{1'b0, 8'h60, P, -1});
        exp_q.push_back('{1'b1, 8'hAA, P, AW});
        exp_q.push_back('{1'b0, 8'hA0, P, -1});
        exp_q.push_back('{1'b1, 8'h55, P, AW});
        req_valid = 1'b1;
        req_reg   = 8'h60;
        req_val   = 8'hAA;
        @(posedge clk);
        #1;
        req_reg = 8'hA0;
        req_val = 8'h55;
        @(negedge clk);
        acc = cyc;
        wait_ready("b2b_first");
        check_lat("b2b_first_latency", acc, 1 + WR_CYC);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        acc = cyc;
        wait_ready("b2b_second");
        check_lat("b2b_second_latency", acc, 1 + WR_CYC);
        check_reg(8'h60, 8'hAA);
        check_reg(8'hA0, 8'h55);
    endtask

    task automatic test_cen_stretch;
        int acc;
        cen_div = 4;
        repeat (8) @(negedge clk);
        chip_regs[8'h20] = 8'h00;
        send_write(8'h20, 8'h01, 1'b1, acc);
        wait_ready("cen_ready");
        check_lat("cen_latency", acc, 1 + 4 * WR_CYC);
        check_reg(8'h20, 8'h01);
        cen_div = 1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_awr;
        int acc, ns;
        send_write(8'h33, 8'h44, 1'b0, acc);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({opl_cs_n, opl_wr_n, req_ready, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL midreset_async: cs_n/wr_n/ready/busy=%b%b%b%b, required 1100", opl_cs_n, opl_wr_n, req_ready, busy);
        end
        exp_q.delete();
        ns = n_strobes;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ready: ready=%b busy=%b, required 1 0", req_ready, busy);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (n_strobes != ns || opl_cs_n !== 1'b1) begin
            errors++;
            $display("FAIL midreset_quiet: %0d strobes after reset, cs_n=%b, required 0 and 1", n_strobes - ns, opl_cs_n);
        end
    endtask

`ifdef JTOPL_HOST_IRQACK_EN
    task automatic test_irq_ack;
        int acc;
        n_ack = 0;
        send_write(8'h20, 8'h11, 1'b0, acc);
        repeat (20) @(negedge clk);
        opl_irq_n = 1'b0;
        exp_q.push_back('{1'b0, 8'h04, P, -1});
        exp_q.push_back('{1'b1, 8'h80, P, AW});
        exp_q.push_back('{1'b0, 8'h30, P, -1});
        exp_q.push_back('{1'b1, 8'h22, P, AW});
        req_valid = 1'b1;
        req_reg   = 8'h30;
        req_val   = 8'h22;
        @(negedge clk);
        wait_ready("irq_new");
        check_lat("irq_latency", acc, 2 + 2 * WR_CYC);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        opl_irq_n = 1'b1;
        @(negedge clk);
        wait_ready("irq_done");
        checks++;
        if (n_ack != 1) begin
            errors++;
            $display("FAIL irq_ack_count: got %0d pulses, required 1", n_ack);
        end
        check_reg(8'h04, 8'h80);
        check_reg(8'h30, 8'h22);
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) chip_regs[i] = 8'h00;
        test_reset();
        test_single_write();
        test_status();
        test_stat_vs_write();
        test_back_to_back();
        test_cen_stretch();
        test_reset_mid_awr();
`ifdef JTOPL_HOST_IRQACK_EN
        test_irq_ack();
`endif
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || stat_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d strobes and %0d status reads outstanding, required 0 and 0", exp_q.size(), stat_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
